// File: rtl/elevator_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_controller_if
//  Brief    : Request/clear handshake between the button latch and the car
//             controller. Latch drives active_*, controller returns inactive_*.
//  Revision : 1.0 - initial release
// ============================================================================
interface elevator_controller_if #(
    parameter int BUTTONS_WIDTH = 8
);
    logic [BUTTONS_WIDTH-1:0] active_in_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] active_out_down_levels;
    logic [BUTTONS_WIDTH-1:0] inactive_in_levels;
    logic [BUTTONS_WIDTH-1:0] inactive_out_up_levels;
    logic [BUTTONS_WIDTH-1:0] inactive_out_down_levels;

    modport master (
        output active_in_levels,
        output active_out_up_levels,
        output active_out_down_levels,
        input  inactive_in_levels,
        input  inactive_out_up_levels,
        input  inactive_out_down_levels
    );

    modport slave (
        input  active_in_levels,
        input  active_out_up_levels,
        input  active_out_down_levels,
        output inactive_in_levels,
        output inactive_out_up_levels,
        output inactive_out_down_levels
    );
endinterface
`default_nettype wire

// File: rtl/elevator_controller.sv
`default_nettype none
// ============================================================================
//  Module   : elevator_controller
//  Brief    : SCAN car-motion controller; retires serviced requests with a
//             one-cycle clear pulse on entry to the door-open state.
//  Revision : 1.0 - initial release
// ============================================================================
module elevator_controller #(
    parameter int BUTTONS_WIDTH = 8,
    parameter int FLOOR_W       = 3,
    parameter int MOVE_CYCLES   = 16,
    parameter int DOOR_CYCLES   = 8
) (
    input  wire logic              clk,
    input  wire logic              reset,
    elevator_controller_if.slave   bus,
    output logic [FLOOR_W-1:0]     current_floor,
    output logic                   dir_up,
    output logic                   moving,
    output logic                   door_open
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_MOVE   = 2'd1;
    localparam logic [1:0] c_ARRIVE = 2'd2;
    localparam logic [1:0] c_DOOR   = 2'd3;

    localparam int c_CNT_MAX = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]       c_MOVE_LAST = c_CNT_W'(MOVE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]       c_DOOR_LAST = c_CNT_W'(DOOR_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]       c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [FLOOR_W-1:0]       c_FLOOR_ONE = FLOOR_W'(1);
    localparam logic [BUTTONS_WIDTH-1:0] c_BIT0      = BUTTONS_WIDTH'(1);

    logic [1:0]               r_state;
    logic [FLOOR_W-1:0]       r_floor;
    logic                     r_dir_up;
    logic [c_CNT_W-1:0]       r_cnt;
    logic [BUTTONS_WIDTH-1:0] r_clr_in;
    logic [BUTTONS_WIDTH-1:0] r_clr_up;
    logic [BUTTONS_WIDTH-1:0] r_clr_dn;

    logic [1:0]               w_state_nxt;
    logic [FLOOR_W-1:0]       w_floor_nxt;
    logic                     w_dir_nxt;
    logic [c_CNT_W-1:0]       w_cnt_nxt;
    logic [BUTTONS_WIDTH-1:0] w_clr_in_nxt;
    logic [BUTTONS_WIDTH-1:0] w_clr_up_nxt;
    logic [BUTTONS_WIDTH-1:0] w_clr_dn_nxt;

    logic [BUTTONS_WIDTH-1:0] w_req;
    logic [BUTTONS_WIDTH-1:0] w_onehot;
    logic                     w_above;
    logic                     w_below;
    logic                     w_ahead;
    logic                     w_here_in;
    logic                     w_here_up;
    logic                     w_here_dn;
    logic                     w_match;
    logic                     w_opp;
    logic                     w_take_opp;
    logic                     w_stop;
    logic                     w_serve;

    // Request summary relative to the current floor
    always_comb begin
        w_req   = bus.active_in_levels | bus.active_out_up_levels | bus.active_out_down_levels;
        w_above = 1'b0;
        w_below = 1'b0;
        for (int i = 0; i < BUTTONS_WIDTH; i++) begin
            if (i > int'(r_floor)) w_above = w_above | w_req[i];
            if (i < int'(r_floor)) w_below = w_below | w_req[i];
        end
        w_ahead    = r_dir_up ? w_above : w_below;
        w_here_in  = bus.active_in_levels[r_floor];
        w_here_up  = bus.active_out_up_levels[r_floor];
        w_here_dn  = bus.active_out_down_levels[r_floor];
        w_match    = r_dir_up ? w_here_up : w_here_dn;
        w_opp      = r_dir_up ? w_here_dn : w_here_up;
        w_take_opp = w_opp & ~w_ahead & ~w_match;
        // An opposite-direction call with work still ahead is not servable
        // here; IDLE then moves on instead of cycling the door forever.
        w_stop     = w_here_in | w_match | w_take_opp;
        w_serve    = ((r_state == c_IDLE) || (r_state == c_ARRIVE)) && w_stop;
        w_onehot   = c_BIT0 << r_floor;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_floor  <= '0;
            r_dir_up <= 1'b1;
            r_cnt    <= '0;
            r_clr_in <= '0;
            r_clr_up <= '0;
            r_clr_dn <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_floor  <= w_floor_nxt;
            r_dir_up <= w_dir_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clr_in <= w_clr_in_nxt;
            r_clr_up <= w_clr_up_nxt;
            r_clr_dn <= w_clr_dn_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_dir_nxt    = r_dir_up;
        w_cnt_nxt    = r_cnt;
        w_clr_in_nxt = '0;
        w_clr_up_nxt = '0;
        w_clr_dn_nxt = '0;

        case (r_state)
            c_IDLE: begin
                if (w_stop) begin
                    w_state_nxt = c_DOOR;
                end else if (w_ahead) begin
                    w_state_nxt = c_MOVE;
                    w_cnt_nxt   = '0;
                end else if (w_above) begin
                    w_dir_nxt   = 1'b1;
                    w_state_nxt = c_MOVE;
                    w_cnt_nxt   = '0;
                end else if (w_below) begin
                    w_dir_nxt   = 1'b0;
                    w_state_nxt = c_MOVE;
                    w_cnt_nxt   = '0;
                end
            end
            c_MOVE: begin
                if (r_cnt == c_MOVE_LAST) begin
                    w_floor_nxt = r_dir_up ? (r_floor + c_FLOOR_ONE) : (r_floor - c_FLOOR_ONE);
                    w_state_nxt = c_ARRIVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
            c_ARRIVE: begin
                if (w_stop) begin
                    w_state_nxt = c_DOOR;
                end else if (w_ahead) begin
                    w_state_nxt = c_MOVE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: begin
                if (r_cnt == c_DOOR_LAST) begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                end
            end
        endcase

        // Service: clear car call, the hall call in travel direction, and the
        // opposite one only when it is the last thing to do here (with a flip).
        if (w_serve) begin
            w_cnt_nxt    = '0;
            w_clr_in_nxt = w_here_in ? w_onehot : '0;
            w_clr_up_nxt = (r_dir_up ? w_match : w_take_opp) ? w_onehot : '0;
            w_clr_dn_nxt = (r_dir_up ? w_take_opp : w_match) ? w_onehot : '0;
            w_dir_nxt    = r_dir_up ^ w_take_opp;
        end
    end

    always_comb begin
        current_floor                = r_floor;
        dir_up                       = r_dir_up;
        moving                       = (r_state == c_MOVE);
        door_open                    = (r_state == c_DOOR);
        bus.inactive_in_levels       = r_clr_in;
        bus.inactive_out_up_levels   = r_clr_up;
        bus.inactive_out_down_levels = r_clr_dn;
    end

endmodule
`default_nettype wire
